// File: rtl/arm_pkg.sv
// rtl/arm_pkg.sv - shared types and encodings for the multicycle ARM controller
package arm_pkg;

  typedef enum logic [3:0] {
    FETCH,
    DECODE,
    MEMADR,
    MEMREAD,
    MEMWB,
    MEMWRITE,
    EXECUTER,
    EXECUTEI,
    ALUWB,
    BRANCH
  } state_t;

  // ALU operation select
  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_AND = 3'd2;
  localparam logic [2:0] ALU_ORR = 3'd3;
  localparam logic [2:0] ALU_EOR = 3'd4;

  // Writeback / PC result select
  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_DATA   = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;

  // ALU operand selects
  localparam logic [1:0] SRCA_REG    = 2'b00;
  localparam logic [1:0] SRCA_PC     = 2'b01;
  localparam logic [1:0] SRCA_ALUOUT = 2'b10;
  localparam logic [1:0] SRCB_REG    = 2'b00;
  localparam logic [1:0] SRCB_IMM    = 2'b01;
  localparam logic [1:0] SRCB_FOUR   = 2'b10;

  // Instruction classes (op field)
  localparam logic [1:0] OP_DP  = 2'b00;
  localparam logic [1:0] OP_MEM = 2'b01;
  localparam logic [1:0] OP_BR  = 2'b10;

  // Data-processing cmd field
  localparam logic [3:0] CMD_AND = 4'b0000;
  localparam logic [3:0] CMD_EOR = 4'b0001;
  localparam logic [3:0] CMD_SUB = 4'b0010;
  localparam logic [3:0] CMD_ADD = 4'b0100;
  localparam logic [3:0] CMD_CMP = 4'b1010;
  localparam logic [3:0] CMD_ORR = 4'b1100;

  // Condition codes
  localparam logic [3:0] COND_EQ = 4'b0000;
  localparam logic [3:0] COND_NE = 4'b0001;
  localparam logic [3:0] COND_CS = 4'b0010;
  localparam logic [3:0] COND_CC = 4'b0011;
  localparam logic [3:0] COND_MI = 4'b0100;
  localparam logic [3:0] COND_PL = 4'b0101;
  localparam logic [3:0] COND_VS = 4'b0110;
  localparam logic [3:0] COND_VC = 4'b0111;
  localparam logic [3:0] COND_HI = 4'b1000;
  localparam logic [3:0] COND_LS = 4'b1001;
  localparam logic [3:0] COND_GE = 4'b1010;
  localparam logic [3:0] COND_LT = 4'b1011;
  localparam logic [3:0] COND_GT = 4'b1100;
  localparam logic [3:0] COND_LE = 4'b1101;
  localparam logic [3:0] COND_AL = 4'b1110;

  // Bit positions inside NZCV
  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

endpackage

// File: rtl/arm_multicycle_controller_condition_check.sv
// rtl/arm_multicycle_controller_condition_check.sv - Armv4 condition evaluation against stored NZCV
module condition_check
  import arm_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] flags,
  output logic       cond_ex
);

  logic n, z, c, v;

  assign n = flags[FLAG_N];
  assign z = flags[FLAG_Z];
  assign c = flags[FLAG_C];
  assign v = flags[FLAG_V];

  // Decode the condition field; 1111 (NV) never executes
  always_comb begin
    cond_ex = 1'b0;
    case (cond)
      COND_EQ: cond_ex = z;
      COND_NE: cond_ex = ~z;
      COND_CS: cond_ex = c;
      COND_CC: cond_ex = ~c;
      COND_MI: cond_ex = n;
      COND_PL: cond_ex = ~n;
      COND_VS: cond_ex = v;
      COND_VC: cond_ex = ~v;
      COND_HI: cond_ex = c & ~z;
      COND_LS: cond_ex = ~c | z;
      COND_GE: cond_ex = (n == v);
      COND_LT: cond_ex = (n != v);
      COND_GT: cond_ex = ~z & (n == v);
      COND_LE: cond_ex = z | (n != v);
      COND_AL: cond_ex = 1'b1;
      default: cond_ex = 1'b0;
    endcase
  end

endmodule

// File: rtl/arm_multicycle_controller.sv
// rtl/arm_multicycle_controller.sv - multicycle FSM controller with NZCV flags and condition gating
module arm_multicycle_controller
  import arm_pkg::*;
#(
  parameter int EXTENDED_OPS      = 1,
  parameter int ALU_CONTROL_WIDTH = 3
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic [19:0]                  instruction,
  input  logic [3:0]                   ALU_flags,
  input  logic                         mem_ready,
  output logic                         mem_request,
  output logic                         write_memory,
  output logic                         pc_write,
  output logic                         ir_write,
  output logic                         write_register,
  output logic                         adr_source,
  output logic [1:0]                   ALU_source_a,
  output logic [1:0]                   ALU_source_b,
  output logic [1:0]                   result_source,
  output logic [1:0]                   immediate_source,
  output logic [1:0]                   register_source,
  output logic [ALU_CONTROL_WIDTH-1:0] ALU_control
);

  localparam logic EXT = (EXTENDED_OPS != 0);

  state_t     state, next_state;
  logic [3:0] flags;
  logic       cond_ex;

  logic [3:0] cond;
  logic [1:0] op;
  logic [5:0] funct;
  logic [3:0] cmd;
  logic [3:0] rd;
  logic       unused_rn;

  assign cond      = instruction[19:16];
  assign op        = instruction[15:14];
  assign funct     = instruction[13:8];
  assign cmd       = funct[4:1];
  assign rd        = instruction[3:0];
  assign unused_rn = ^instruction[7:4];

  // Immediate extension and register-read muxes follow the instruction class only
  assign immediate_source = op;
  assign register_source  = {(op == OP_MEM) && !funct[0], (op == OP_BR)};

  condition_check u_condition_check (
    .cond    (cond),
    .flags   (flags),
    .cond_ex (cond_ex)
  );

  logic       dp_ok;
  logic       dp_logic;
  logic       dp_cmp;
  logic [2:0] dp_alu;

  // Classify the data-processing command: ALU op, whether it is legal, logical or a compare
  always_comb begin
    dp_ok    = 1'b0;
    dp_logic = 1'b0;
    dp_cmp   = 1'b0;
    dp_alu   = ALU_ADD;
    case (cmd)
      CMD_ADD: begin dp_ok = 1'b1; dp_alu = ALU_ADD; end
      CMD_SUB: begin dp_ok = 1'b1; dp_alu = ALU_SUB; end
      CMD_AND: begin dp_ok = 1'b1; dp_alu = ALU_AND; dp_logic = 1'b1; end
      CMD_ORR: begin dp_ok = 1'b1; dp_alu = ALU_ORR; dp_logic = 1'b1; end
      CMD_EOR: begin dp_ok = EXT;  dp_alu = ALU_EOR; dp_logic = 1'b1; end
      CMD_CMP: begin dp_ok = EXT;  dp_alu = ALU_SUB; dp_cmp = EXT; end
      default: begin dp_ok = 1'b0; end
    endcase
  end

  logic in_execute;
  logic flags_we;

  assign in_execute = (state == EXECUTER) || (state == EXECUTEI);
  assign flags_we   = in_execute && cond_ex && dp_ok && (funct[0] || dp_cmp);

  // State register; reset abandons any in-flight access and restarts at FETCH
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= FETCH;
    else        state <= next_state;
  end

  // Architectural NZCV; logical ops keep C and V
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      flags <= 4'b0000;
    end else if (flags_we) begin
      flags[FLAG_N] <= ALU_flags[FLAG_N];
      flags[FLAG_Z] <= ALU_flags[FLAG_Z];
      if (!dp_logic) begin
        flags[FLAG_C] <= ALU_flags[FLAG_C];
        flags[FLAG_V] <= ALU_flags[FLAG_V];
      end
    end
  end

  logic       mem_request_raw;
  logic       write_memory_raw;
  logic       pc_write_raw;
  logic       ir_write_raw;
  logic       write_register_raw;
  logic [2:0] alu_op;

  // Next-state and datapath control decode
  always_comb begin
    next_state         = state;
    mem_request_raw    = 1'b0;
    write_memory_raw   = 1'b0;
    pc_write_raw       = 1'b0;
    ir_write_raw       = 1'b0;
    write_register_raw = 1'b0;
    adr_source         = 1'b0;
    ALU_source_a       = SRCA_REG;
    ALU_source_b       = SRCB_REG;
    result_source      = RES_ALUOUT;
    alu_op             = ALU_ADD;
    case (state)
      FETCH: begin
        mem_request_raw = 1'b1;
        ALU_source_a    = SRCA_PC;
        ALU_source_b    = SRCB_FOUR;
        result_source   = RES_ALU;
        if (mem_ready) begin
          ir_write_raw = 1'b1;
          pc_write_raw = 1'b1;
          next_state   = DECODE;
        end
      end
      DECODE: begin
        ALU_source_a  = SRCA_PC;
        ALU_source_b  = SRCB_FOUR;
        result_source = RES_ALU;
        case (op)
          OP_DP:   next_state = funct[5] ? EXECUTEI : EXECUTER;
          OP_MEM:  next_state = MEMADR;
          OP_BR:   next_state = BRANCH;
          default: next_state = FETCH;
        endcase
      end
      MEMADR: begin
        ALU_source_b = SRCB_IMM;
        next_state   = funct[0] ? MEMREAD : MEMWRITE;
      end
      MEMREAD: begin
        adr_source      = 1'b1;
        mem_request_raw = 1'b1;
        if (mem_ready) next_state = MEMWB;
      end
      MEMWRITE: begin
        adr_source = 1'b1;
        if (cond_ex) begin
          mem_request_raw  = 1'b1;
          write_memory_raw = 1'b1;
          if (mem_ready) next_state = FETCH;
        end else begin
          next_state = FETCH;
        end
      end
      MEMWB, ALUWB: begin
        result_source = (state == MEMWB) ? RES_DATA : RES_ALUOUT;
        if (cond_ex) begin
          if (rd == 4'd15) pc_write_raw       = 1'b1;
          else             write_register_raw = 1'b1;
        end
        next_state = FETCH;
      end
      EXECUTER, EXECUTEI: begin
        ALU_source_b = (state == EXECUTEI) ? SRCB_IMM : SRCB_REG;
        alu_op       = dp_alu;
        next_state   = (dp_ok && !dp_cmp) ? ALUWB : FETCH;
      end
      BRANCH: begin
        ALU_source_a  = SRCA_ALUOUT;
        ALU_source_b  = SRCB_IMM;
        result_source = RES_ALU;
        pc_write_raw  = cond_ex;
        next_state    = FETCH;
      end
      default: next_state = FETCH;
    endcase
  end

  // Enables are held off for as long as reset is asserted, not just at the edge
  assign mem_request    = mem_request_raw & reset;
  assign write_memory   = write_memory_raw & reset;
  assign pc_write       = pc_write_raw & reset;
  assign ir_write       = ir_write_raw & reset;
  assign write_register = write_register_raw & reset;
  assign ALU_control    = ALU_CONTROL_WIDTH'(alu_op);

endmodule

// File: tb/tb_arm_multicycle_controller.sv
// tb/tb_arm_multicycle_controller.sv - directed self-checking bench for arm_multicycle_controller
module tb_arm_multicycle_controller;
  import arm_pkg::*;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [19:0] instruction = 20'd0;
  logic [3:0]  ALU_flags = 4'd0;
  logic        mem_ready = 1'b0;

  logic       mem_request, write_memory, pc_write, ir_write, write_register, adr_source;
  logic [1:0] ALU_source_a, ALU_source_b, result_source, immediate_source, register_source;
  logic [2:0] ALU_control;

  logic       mem_request_z, write_memory_z, pc_write_z, ir_write_z, write_register_z, adr_source_z;
  logic [1:0] ALU_source_a_z, ALU_source_b_z, result_source_z, immediate_source_z, register_source_z;
  logic [2:0] ALU_control_z;

  int errors = 0;
  int checks = 0;

  arm_multicycle_controller #(.EXTENDED_OPS(1), .ALU_CONTROL_WIDTH(3)) dut (
    .clock(clock), .reset(reset), .instruction(instruction), .ALU_flags(ALU_flags),
    .mem_ready(mem_ready), .mem_request(mem_request), .write_memory(write_memory),
    .pc_write(pc_write), .ir_write(ir_write), .write_register(write_register),
    .adr_source(adr_source), .ALU_source_a(ALU_source_a), .ALU_source_b(ALU_source_b),
    .result_source(result_source), .immediate_source(immediate_source),
    .register_source(register_source), .ALU_control(ALU_control)
  );

  arm_multicycle_controller #(.EXTENDED_OPS(0), .ALU_CONTROL_WIDTH(3)) dut0 (
    .clock(clock), .reset(reset), .instruction(instruction), .ALU_flags(ALU_flags),
    .mem_ready(mem_ready), .mem_request(mem_request_z), .write_memory(write_memory_z),
    .pc_write(pc_write_z), .ir_write(ir_write_z), .write_register(write_register_z),
    .adr_source(adr_source_z), .ALU_source_a(ALU_source_a_z), .ALU_source_b(ALU_source_b_z),
    .result_source(result_source_z), .immediate_source(immediate_source_z),
    .register_source(register_source_z), .ALU_control(ALU_control_z)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    chk(tag, {3'b000, obs}, {3'b000, exp});
  endtask

  task automatic chk2(input string tag, input logic [1:0] obs, input logic [1:0] exp);
    chk(tag, {2'b00, obs}, {2'b00, exp});
  endtask

  task automatic chk3(input string tag, input logic [2:0] obs, input logic [2:0] exp);
    chk(tag, {1'b0, obs}, {1'b0, exp});
  endtask

  function automatic logic [19:0] mk(input logic [3:0] cond, input logic [1:0] op,
                                     input logic [5:0] funct, input logic [3:0] rd);
    return {cond, op, funct, 4'd2, rd};
  endfunction

  task automatic cyc();
    @(posedge clock);
    #2;
  endtask

  // Starts in FETCH with the instruction presented; leaves the bench in DECODE
  task automatic do_fetch(input string tag, input logic [19:0] ins);
    instruction = ins;
    mem_ready   = 1'b1;
    #1;
    chk({tag, ":fetch_state"}, dut.state, FETCH);
    chk1({tag, ":fetch_req"}, mem_request, 1'b1);
    chk1({tag, ":fetch_irw"}, ir_write, 1'b1);
    chk1({tag, ":fetch_pcw"}, pc_write, 1'b1);
    chk1({tag, ":fetch_adr"}, adr_source, 1'b0);
    chk2({tag, ":fetch_srca"}, ALU_source_a, 2'b01);
    chk2({tag, ":fetch_srcb"}, ALU_source_b, 2'b10);
    chk2({tag, ":fetch_res"}, result_source, 2'b10);
    chk3({tag, ":fetch_alu"}, ALU_control, 3'd0);
    cyc();
    chk({tag, ":decode_state"}, dut.state, DECODE);
    chk1({tag, ":decode_req"}, mem_request, 1'b0);
    chk1({tag, ":decode_wr"}, write_register, 1'b0);
  endtask

  initial begin
    // Reset held: enables forced low even with mem_ready high
    mem_ready   = 1'b1;
    instruction = mk(COND_AL, OP_DP, 6'b101000, 4'd1);
    #12;
    chk("rst:state", dut.state, FETCH);
    chk("rst:flags", dut.flags, 4'b0000);
    chk1("rst:req", mem_request, 1'b0);
    chk1("rst:irw", ir_write, 1'b0);
    chk1("rst:pcw", pc_write, 1'b0);
    chk1("rst:wm", write_memory, 1'b0);
    @(negedge clock);
    reset = 1'b1;
    #1;
    chk1("rel:req", mem_request, 1'b1);

    // ADD r1,r2,#5: FETCH, DECODE, EXECUTEI, ALUWB
    do_fetch("add", mk(COND_AL, OP_DP, 6'b101000, 4'd1));
    cyc();
    chk("add:ex_state", dut.state, EXECUTEI);
    chk2("add:ex_srcb", ALU_source_b, 2'b01);
    chk3("add:ex_alu", ALU_control, 3'd0);
    chk1("add:ex_wr", write_register, 1'b0);
    cyc();
    chk("add:wb_state", dut.state, ALUWB);
    chk1("add:wb_wr", write_register, 1'b1);
    chk1("add:wb_pcw", pc_write, 1'b0);
    chk2("add:wb_res", result_source, 2'b00);
    cyc();
    chk("add:next_fetch", dut.state, FETCH);
    chk1("add:next_wr", write_register, 1'b0);

    // SUBS r3,r1,r2 with a zero result
    ALU_flags = 4'b0100;
    do_fetch("subs", mk(COND_AL, OP_DP, 6'b000101, 4'd3));
    cyc();
    chk("subs:ex_state", dut.state, EXECUTER);
    chk3("subs:ex_alu", ALU_control, 3'd1);
    chk2("subs:ex_srcb", ALU_source_b, 2'b00);
    cyc();
    chk("subs:flags", dut.flags, 4'b0100);
    chk1("subs:wb_wr", write_register, 1'b1);
    cyc();

    // ADDNE with Z set: no writeback, back to FETCH
    ALU_flags = 4'b1111;
    do_fetch("addne", mk(COND_NE, OP_DP, 6'b101000, 4'd1));
    cyc();
    cyc();
    chk("addne:wb_state", dut.state, ALUWB);
    chk1("addne:wb_wr", write_register, 1'b0);
    chk1("addne:wb_pcw", pc_write, 1'b0);
    chk("addne:flags", dut.flags, 4'b0100);
    cyc();
    chk("addne:next_fetch", dut.state, FETCH);

    // ADDEQ r15: PC write instead of register write
    do_fetch("addeq15", mk(COND_EQ, OP_DP, 6'b101000, 4'd15));
    cyc();
    cyc();
    chk1("addeq15:pcw", pc_write, 1'b1);
    chk1("addeq15:wr", write_register, 1'b0);
    cyc();

    // cond 1111 never passes
    do_fetch("nv", mk(4'b1111, OP_DP, 6'b101000, 4'd1));
    cyc();
    cyc();
    chk1("nv:wr", write_register, 1'b0);
    cyc();

    // LDR with three wait cycles in MEMREAD
    do_fetch("ldr", mk(COND_AL, OP_MEM, 6'b011001, 4'd4));
    chk2("ldr:immsrc", immediate_source, 2'b01);
    chk2("ldr:regsrc", register_source, 2'b00);
    cyc();
    chk("ldr:adr_state", dut.state, MEMADR);
    chk2("ldr:adr_srca", ALU_source_a, 2'b00);
    chk2("ldr:adr_srcb", ALU_source_b, 2'b01);
    mem_ready = 1'b0;
    cyc();
    for (int i = 0; i < 3; i++) begin
      chk("ldr:wait_state", dut.state, MEMREAD);
      chk1("ldr:wait_adr", adr_source, 1'b1);
      chk1("ldr:wait_req", mem_request, 1'b1);
      cyc();
    end
    mem_ready = 1'b1;
    #1;
    chk("ldr:rd4_state", dut.state, MEMREAD);
    chk1("ldr:rd4_adr", adr_source, 1'b1);
    cyc();
    chk("ldr:wb_state", dut.state, MEMWB);
    chk2("ldr:wb_res", result_source, 2'b01);
    chk1("ldr:wb_wr", write_register, 1'b1);
    cyc();
    chk("ldr:next_fetch", dut.state, FETCH);

    // ADDS sets C and V, then ANDS negative keeps them
    ALU_flags = 4'b0011;
    do_fetch("adds", mk(COND_AL, OP_DP, 6'b101001, 4'd5));
    cyc();
    cyc();
    chk("adds:flags", dut.flags, 4'b0011);
    cyc();
    ALU_flags = 4'b1000;
    do_fetch("ands", mk(COND_AL, OP_DP, 6'b000001, 4'd6));
    cyc();
    chk3("ands:alu", ALU_control, 3'd2);
    cyc();
    chk("ands:flags", dut.flags, 4'b1011);
    chk("ands:flags_z", dut0.flags, 4'b1011);
    cyc();

    // CMP: flags and no writeback when supported; ignored when not
    ALU_flags = 4'b0110;
    do_fetch("cmp", mk(COND_AL, OP_DP, 6'b010101, 4'd0));
    cyc();
    chk("cmp:ex_state", dut.state, EXECUTER);
    chk3("cmp:alu", ALU_control, 3'd1);
    chk1("cmp:wr", write_register, 1'b0);
    chk1("cmp:wr_z", write_register_z, 1'b0);
    chk1("cmp:pcw_z", pc_write_z, 1'b0);
    cyc();
    chk("cmp:fetch", dut.state, FETCH);
    chk("cmp:fetch_z", dut0.state, FETCH);
    chk("cmp:flags", dut.flags, 4'b0110);
    chk("cmp:flags_z", dut0.flags, 4'b1011);

    // STRNE with Z set: one idle MEMWRITE cycle, no wait on memory
    do_fetch("strne", mk(COND_NE, OP_MEM, 6'b011000, 4'd7));
    chk2("strne:regsrc", register_source, 2'b10);
    cyc();
    mem_ready = 1'b0;
    cyc();
    chk("strne:state", dut.state, MEMWRITE);
    chk1("strne:req", mem_request, 1'b0);
    chk1("strne:wm", write_memory, 1'b0);
    chk1("strne:adr", adr_source, 1'b1);
    cyc();
    chk("strne:next_fetch", dut.state, FETCH);

    // STR stalled in MEMWRITE, then reset mid-access
    do_fetch("str", mk(COND_AL, OP_MEM, 6'b011000, 4'd7));
    cyc();
    mem_ready = 1'b0;
    cyc();
    chk1("str:wm", write_memory, 1'b1);
    chk1("str:req", mem_request, 1'b1);
    cyc();
    chk("str:hold_state", dut.state, MEMWRITE);
    reset = 1'b0;
    #1;
    chk1("str:rst_wm", write_memory, 1'b0);
    chk1("str:rst_req", mem_request, 1'b0);
    chk("str:rst_state", dut.state, FETCH);
    chk("str:rst_flags", dut.flags, 4'b0000);
    chk("str:rst_flags_z", dut0.flags, 4'b0000);
    @(negedge clock);
    reset = 1'b1;
    #1;
    chk1("str:rel_req", mem_request, 1'b1);

    // B (taken) and BEQ with Z clear (not taken)
    do_fetch("b", mk(COND_AL, OP_BR, 6'b100000, 4'd0));
    chk2("b:immsrc", immediate_source, 2'b10);
    chk2("b:regsrc", register_source, 2'b01);
    cyc();
    chk("b:state", dut.state, BRANCH);
    chk1("b:pcw", pc_write, 1'b1);
    chk2("b:srca", ALU_source_a, 2'b10);
    chk2("b:srcb", ALU_source_b, 2'b01);
    chk2("b:res", result_source, 2'b10);
    cyc();
    do_fetch("beq", mk(COND_EQ, OP_BR, 6'b100000, 4'd0));
    cyc();
    chk1("beq:pcw", pc_write, 1'b0);
    cyc();
    chk("beq:next_fetch", dut.state, FETCH);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
